// File: rtl/nap_countdown.sv
// Kitchen-style MM:SS countdown (max 9:59) with a timed alarm phase.
// Digits are BCD from a keypad selector; a rising completeSetting loads
// and starts the count, stop aborts a run or acknowledges the alarm.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a load request; counters show last value / zero
// RUN    | counting down one second per tick
// ALARM  | count reached 0:00; alarm held for ALARM_SEC ticks or until stop
module nap_countdown #(
    parameter int unsigned ALARM_SEC = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] one_sec,
    input  logic [3:0] ten_sec,
    input  logic [3:0] one_min,
    input  logic       completeSetting,
    input  logic       stop,
    output logic [3:0] cnt_one_sec,
    output logic [3:0] cnt_ten_sec,
    output logic [3:0] cnt_one_min,
    output logic       running,
    output logic       alarm,
    output logic       load_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ALARM = 2'd2
    } state_t;

    localparam logic [4:0] ALARM_LAST = 5'(ALARM_SEC);

    state_t     state_q, state_d;
    logic [3:0] one_q, one_d;
    logic [3:0] ten_q, ten_d;
    logic [3:0] min_q, min_d;
    logic [3:0] alm_cnt_q, alm_cnt_d;
    logic       armed_q, armed_d;
    logic       running_q, running_d;
    logic       alarm_q, alarm_d;
    logic       load_err_q, load_err_d;

    logic       digits_ok;
    logic       digits_zero;
    logic       count_zero;
    logic       count_one;
    logic [4:0] alm_cnt_inc;

    assign digits_ok   = (one_sec <= 4'd9) && (ten_sec <= 4'd5) && (one_min <= 4'd9);
    assign digits_zero = (one_sec == 4'd0) && (ten_sec == 4'd0) && (one_min == 4'd0);
    assign count_zero  = (one_q == 4'd0) && (ten_q == 4'd0) && (min_q == 4'd0);
    assign count_one   = (one_q == 4'd1) && (ten_q == 4'd0) && (min_q == 4'd0);
    assign alm_cnt_inc = {1'b0, alm_cnt_q} + 5'd1;

    // Next-state, counter and output decode.
    always_comb begin
        state_d    = state_q;
        one_d      = one_q;
        ten_d      = ten_q;
        min_d      = min_q;
        alm_cnt_d  = alm_cnt_q;
        // Any low cycle re-arms the load request; a load attempt disarms it.
        armed_d    = armed_q | ~completeSetting;
        load_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!stop && completeSetting && armed_q) begin
                    armed_d = 1'b0;
                    if (digits_ok) begin
                        one_d = one_sec;
                        ten_d = ten_sec;
                        min_d = one_min;
                        if (digits_zero) begin
                            state_d   = S_ALARM;
                            alm_cnt_d = 4'd0;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (stop) begin
                    one_d   = 4'd0;
                    ten_d   = 4'd0;
                    min_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (count_one || count_zero) begin
                        // Last second expires (zero guard keeps the count from wrapping).
                        one_d     = 4'd0;
                        ten_d     = 4'd0;
                        min_d     = 4'd0;
                        state_d   = S_ALARM;
                        alm_cnt_d = 4'd0;
                    end else if (one_q != 4'd0) begin
                        one_d = one_q - 4'd1;
                    end else begin
                        one_d = 4'd9;
                        if (ten_q != 4'd0) begin
                            ten_d = ten_q - 4'd1;
                        end else begin
                            ten_d = 4'd5;
                            min_d = min_q - 4'd1;
                        end
                    end
                end
            end

            S_ALARM: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    alm_cnt_d = 4'd0;
                end else if (tick) begin
                    if (alm_cnt_inc >= ALARM_LAST) begin
                        state_d   = S_IDLE;
                        alm_cnt_d = 4'd0;
                    end else begin
                        alm_cnt_d = alm_cnt_inc[3:0];
                    end
                end
            end

            default: begin
                state_d   = S_IDLE;
                one_d     = 4'd0;
                ten_d     = 4'd0;
                min_d     = 4'd0;
                alm_cnt_d = 4'd0;
            end
        endcase

        running_d = (state_d == S_RUN);
        alarm_d   = (state_d == S_ALARM);
    end

    // State, counters and registered outputs; reset leaves the load tracker disarmed.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            one_q      <= 4'd0;
            ten_q      <= 4'd0;
            min_q      <= 4'd0;
            alm_cnt_q  <= 4'd0;
            armed_q    <= 1'b0;
            running_q  <= 1'b0;
            alarm_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            one_q      <= one_d;
            ten_q      <= ten_d;
            min_q      <= min_d;
            alm_cnt_q  <= alm_cnt_d;
            armed_q    <= armed_d;
            running_q  <= running_d;
            alarm_q    <= alarm_d;
            load_err_q <= load_err_d;
        end
    end

    assign cnt_one_sec = one_q;
    assign cnt_ten_sec = ten_q;
    assign cnt_one_min = min_q;
    assign running     = running_q;
    assign alarm       = alarm_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_nap_countdown.sv
// Bench for nap_countdown: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a seconds-based model.
module tb_nap_countdown;

    localparam int ALARM_SEC = 10;

    logic       clock = 1'b0;
    logic       reset, tick, completeSetting, stop;
    logic [3:0] one_sec, ten_sec, one_min;
    logic [3:0] cnt_one_sec, cnt_ten_sec, cnt_one_min;
    logic       running, alarm, load_err;

    int tests  = 0;
    int errors = 0;

    nap_countdown #(.ALARM_SEC(ALARM_SEC)) dut (
        .clock           (clock),
        .reset           (reset),
        .tick            (tick),
        .one_sec         (one_sec),
        .ten_sec         (ten_sec),
        .one_min         (one_min),
        .completeSetting (completeSetting),
        .stop            (stop),
        .cnt_one_sec     (cnt_one_sec),
        .cnt_ten_sec     (cnt_ten_sec),
        .cnt_one_min     (cnt_one_min),
        .running         (running),
        .alarm           (alarm),
        .load_err        (load_err)
    );

    always #5 clock = ~clock;

    // Reference model: remaining time as plain seconds, mode flags, alarm tick count.
    int m_secs    = 0;
    bit m_run     = 0;
    bit m_alarm   = 0;
    bit m_err     = 0;
    int m_aticks  = 0;
    bit m_armed   = 0;

    task automatic model_step();
        bit attempt;
        int val;
        if (reset) begin
            m_secs = 0; m_run = 0; m_alarm = 0; m_err = 0; m_aticks = 0; m_armed = 0;
            return;
        end
        m_err   = 0;
        attempt = 0;
        if (!m_run && !m_alarm) begin
            if (!stop && completeSetting && m_armed) begin
                attempt = 1;
                if (one_sec <= 9 && ten_sec <= 5 && one_min <= 9) begin
                    val    = int'(one_sec) + 10 * int'(ten_sec) + 60 * int'(one_min);
                    m_secs = val;
                    if (val == 0) begin m_alarm = 1; m_aticks = 0; end
                    else m_run = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_run) begin
            if (stop) begin
                m_secs = 0; m_run = 0;
            end else if (tick) begin
                m_secs = m_secs - 1;
                if (m_secs <= 0) begin
                    m_secs = 0; m_run = 0; m_alarm = 1; m_aticks = 0;
                end
            end
        end else begin
            if (stop) m_alarm = 0;
            else if (tick) begin
                m_aticks++;
                if (m_aticks >= ALARM_SEC) m_alarm = 0;
            end
        end
        if (!completeSetting) m_armed = 1;
        else if (attempt)     m_armed = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, ".one"}, cnt_one_sec, m_secs % 10);
        chk({name, ".ten"}, cnt_ten_sec, (m_secs / 10) % 6);
        chk({name, ".min"}, cnt_one_min, m_secs / 60);
        chk({name, ".run"}, running, m_run);
        chk({name, ".alm"}, alarm, m_alarm);
        chk({name, ".err"}, load_err, m_err);
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic cyc(input bit r, input bit tk, input int o, input int t, input int m,
                       input bit cs, input bit st);
        reset = r; tick = tk; one_sec = 4'(o); ten_sec = 4'(t); one_min = 4'(m);
        completeSetting = cs; stop = st;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_cnt(input string name, input int o, input int t, input int m,
                           input int r, input int a);
        chk({name, ".one"}, cnt_one_sec, o);
        chk({name, ".ten"}, cnt_ten_sec, t);
        chk({name, ".min"}, cnt_one_min, m);
        chk({name, ".run"}, running, r);
        chk({name, ".alm"}, alarm, a);
    endtask

    typedef struct {
        bit r, tk, cs, st;
        int o, t, m;
        int eo, et, em;
        bit er, ea, ee;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(bit r, bit tk, int o, int t, int m, bit cs, bit st,
                               int eo, int et, int em, bit er, bit ea, bit ee);
        vec_t x;
        x.r = r; x.tk = tk; x.o = o; x.t = t; x.m = m; x.cs = cs; x.st = st;
        x.eo = eo; x.et = et; x.em = em; x.er = er; x.ea = ea; x.ee = ee;
        return x;
    endfunction

    initial begin
        //        r tk o t m cs st   eo et em run alm err
        vt.push_back(v(1,0,0,0,0,0,0,  0,0,0, 0,0,0)); // reset
        vt.push_back(v(0,0,3,0,0,1,0,  0,0,0, 0,0,0)); // cs high since reset: no load
        vt.push_back(v(0,0,3,0,0,0,0,  0,0,0, 0,0,0)); // arm
        vt.push_back(v(0,0,3,0,0,1,0,  3,0,0, 1,0,0)); // load 0:03
        vt.push_back(v(0,1,7,0,0,1,0,  2,0,0, 1,0,0)); // tick, cs ignored
        vt.push_back(v(0,0,0,0,0,0,0,  2,0,0, 1,0,0)); // hold without tick
        vt.push_back(v(0,1,0,0,0,0,0,  1,0,0, 1,0,0));
        vt.push_back(v(0,1,0,0,0,0,0,  0,0,0, 0,1,0)); // 0:01 -> alarm
        vt.push_back(v(0,0,0,0,0,0,1,  0,0,0, 0,0,0)); // ack alarm
        vt.push_back(v(0,0,0,6,0,1,0,  0,0,0, 0,0,1)); // ten_sec=6 rejected
        vt.push_back(v(0,0,0,6,0,1,0,  0,0,0, 0,0,0)); // held: single pulse
        vt.push_back(v(0,0,0,0,0,0,0,  0,0,0, 0,0,0));
        vt.push_back(v(0,0,0,0,1,1,1,  0,0,0, 0,0,0)); // stop beats load
        vt.push_back(v(0,0,0,0,1,1,0,  0,0,1, 1,0,0)); // load 1:00
        vt.push_back(v(0,1,0,0,0,0,0,  9,5,0, 1,0,0)); // borrow through both digits
        vt.push_back(v(0,1,0,0,0,0,1,  0,0,0, 0,0,0)); // stop beats tick
        vt.push_back(v(0,0,0,0,0,0,0,  0,0,0, 0,0,0));
        vt.push_back(v(0,0,0,0,0,1,0,  0,0,0, 0,1,0)); // load 0:00 -> alarm
        vt.push_back(v(0,1,0,0,0,0,0,  0,0,0, 0,1,0));
        vt.push_back(v(0,0,0,0,0,0,0,  0,0,0, 0,1,0));
        vt.push_back(v(1,0,0,0,0,0,0,  0,0,0, 0,0,0)); // reset out of alarm
        vt.push_back(v(0,0,9,5,9,0,0,  0,0,0, 0,0,0));
        vt.push_back(v(0,0,9,5,9,1,0,  9,5,9, 1,0,0)); // max load 9:59
        vt.push_back(v(0,0,9,5,9,0,1,  0,0,0, 0,0,0));

        foreach (vt[i]) begin
            cyc(vt[i].r, vt[i].tk, vt[i].o, vt[i].t, vt[i].m, vt[i].cs, vt[i].st);
            chk_cnt($sformatf("vec%0d", i), vt[i].eo, vt[i].et, vt[i].em, vt[i].er, vt[i].ea);
            chk($sformatf("vec%0d.err", i), load_err, vt[i].ee);
        end

        // Load 0:05, five spaced ticks -> alarm.
        cyc(0,0,5,0,0,0,0);
        cyc(0,0,5,0,0,1,0);
        chk_cnt("load5", 5,0,0, 1,0);
        for (int k = 0; k < 5; k++) begin
            cyc(0,1,0,0,0,0,0);
            cyc(0,0,0,0,0,0,0);
        end
        chk_cnt("five_ticks", 0,0,0, 0,1);
        cyc(0,0,0,0,0,0,1);
        chk_cnt("ack5", 0,0,0, 0,0);

        // Load 1:00, 1 tick -> 0:59, 30 more -> 0:29.
        cyc(0,0,0,0,1,1,0);
        chk_cnt("load100", 0,0,1, 1,0);
        cyc(0,1,0,0,0,0,0);
        chk_cnt("t059", 9,5,0, 1,0);
        for (int k = 0; k < 30; k++) cyc(0,1,0,0,0,0,0);
        chk_cnt("t029", 9,2,0, 1,0);
        cyc(0,0,0,0,0,0,1);

        // 0:03 with stop and tick together -> idle, 0:00, no alarm.
        cyc(0,0,3,0,0,1,0);
        chk_cnt("load3", 3,0,0, 1,0);
        cyc(0,1,0,0,0,0,1);
        chk_cnt("stop_tick", 0,0,0, 0,0);

        // Alarm runs exactly ALARM_SEC ticks.
        cyc(0,0,0,0,0,1,0);
        chk_cnt("alm_enter", 0,0,0, 0,1);
        for (int k = 1; k < ALARM_SEC; k++) begin
            cyc(0,1,0,0,0,0,0);
            cyc(0,0,0,0,0,0,0);
            chk($sformatf("alm_hold%0d", k), alarm, 1);
        end
        cyc(0,1,0,0,0,0,0);
        chk_cnt("alm_expire", 0,0,0, 0,0);

        // Alarm acknowledged after two ticks.
        cyc(0,0,0,0,0,1,0);
        chk_cnt("alm2_enter", 0,0,0, 0,1);
        cyc(0,1,0,0,0,0,0);
        cyc(0,1,0,0,0,0,0);
        chk("alm2_two", alarm, 1);
        cyc(0,1,0,0,0,0,1);
        chk_cnt("alm2_stop", 0,0,0, 0,0);

        // Reset mid-run at 0:30 with completeSetting held through and after reset.
        cyc(0,0,0,3,0,0,0);
        cyc(0,0,0,3,0,1,0);
        chk_cnt("load030", 0,3,0, 1,0);
        cyc(1,1,0,3,0,1,0);
        chk_cnt("rst_run", 0,0,0, 0,0);
        for (int k = 0; k < 3; k++) cyc(0,0,0,3,0,1,0);
        chk_cnt("rst_hold_cs", 0,0,0, 0,0);
        cyc(0,0,0,3,0,0,0);
        cyc(0,0,0,3,0,1,0);
        chk_cnt("reload030", 0,3,0, 1,0);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bit r, tk, cs, st;
            int o, t, m;
            r  = ($urandom_range(0, 99) == 0);
            tk = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 19) == 0);
            cs = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                o = $urandom_range(0, 15); t = $urandom_range(0, 15); m = $urandom_range(0, 15);
            end else begin
                o = $urandom_range(0, 9);  t = $urandom_range(0, 5);
                m = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 9);
            end
            cyc(r, tk, o, t, m, cs, st);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
